// File: rtl/f51m_sched.sv
// ---------------------------------------------------------------------------
// f51m_sched
//   Two-requester scheduler for one shared combinational 8-in/8-out function
//   unit. One operation is in flight at a time: a request is accepted in
//   IDLE, the operand is held on fu_in for FU_LAT cycles (EXEC), and fu_out
//   is captured on the last EXEC cycle. The result is then offered to the
//   owning requester (RESP) until it is consumed. Grants are round-robin and
//   a per-requester count of completed responses is kept.
//
// Parameters
//   FU_LAT      : 1..7, settle time of the shared unit in cycles
//
// Ports
//   clk         : clock, all state on rising edge
//   rst         : synchronous active-high reset
//   reqN_valid  : request valid            (N = 0,1)
//   reqN_data   : request operand, 8 bit
//   reqN_ready  : request accepted when valid & ready
//   rspN_valid  : response valid
//   rspN_data   : response result, 8 bit
//   rspN_ready  : response consumed when valid & ready
//   fu_in       : operand to the shared unit
//   fu_out      : result from the shared unit
//   busy        : high whenever not IDLE
//   opsN_cnt    : completed-response count, wraps at 256
// ---------------------------------------------------------------------------
module f51m_sched #(
  parameter int unsigned FU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp0_data,
  output logic [7:0] rsp1_data,
  input  logic       rsp0_ready,
  input  logic       rsp1_ready,
  output logic [7:0] fu_in,
  input  logic [7:0] fu_out,
  output logic       busy,
  output logic [7:0] ops0_cnt,
  output logic [7:0] ops1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT3 = 3'(FU_LAT);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_op;
  logic [7:0] r_res;
  logic       r_owner;
  logic       r_last;
  logic [2:0] r_cnt;
  logic [7:0] r_ops0;
  logic [7:0] r_ops1;
  logic       r_rst_q;

  logic       w_quiet;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_acc;
  logic       w_last_exec;
  logic       w_rsp_hs;

  // Outputs are forced to zero while reset is asserted and for one cycle
  // after it, so no request can be accepted in the post-reset cycle.
  assign w_quiet = rst | r_rst_q;

  // Round-robin grant: a tie goes to the requester not granted last time.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt0 = r_last;
      w_gnt1 = ~r_last;
    end else if (req0_valid) begin
      w_gnt0 = 1'b1;
    end else if (req1_valid) begin
      w_gnt1 = 1'b1;
    end
  end

  assign w_rdy0      = (r_state == IDLE) && !w_quiet && w_gnt0;
  assign w_rdy1      = (r_state == IDLE) && !w_quiet && w_gnt1;
  assign w_acc0      = w_rdy0 && req0_valid;
  assign w_acc1      = w_rdy1 && req1_valid;
  assign w_acc       = w_acc0 || w_acc1;
  assign w_last_exec = (r_state == EXEC) && (r_cnt == 3'd1);
  assign w_rsp_hs    = (r_state == RESP) && !w_quiet &&
                       (r_owner ? rsp1_ready : rsp0_ready);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc)       w_next = EXEC;
      EXEC:    if (w_last_exec) w_next = RESP;
      RESP:    if (w_rsp_hs)    w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_res   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_ops0  <= '0;
      r_ops1  <= '0;
      r_rst_q <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
      if (w_acc) begin
        r_op    <= w_acc1 ? req1_data : req0_data;
        r_owner <= w_acc1;
        r_cnt   <= LAT3;
      end
      if (r_state == EXEC) begin
        r_cnt <= r_cnt - 3'd1;
        if (w_last_exec) begin
          r_res <= fu_out;
        end
      end
      if (w_rsp_hs) begin
        r_last <= r_owner;
        if (r_owner) begin
          r_ops1 <= r_ops1 + 8'd1;
        end else begin
          r_ops0 <= r_ops0 + 8'd1;
        end
      end
    end
  end

  // Output drive, all gated to zero in the reset window
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    fu_in      = '0;
    busy       = 1'b0;
    ops0_cnt   = '0;
    ops1_cnt   = '0;
    if (!w_quiet) begin
      req0_ready = w_rdy0;
      req1_ready = w_rdy1;
      fu_in      = r_op;
      busy       = (r_state != IDLE);
      ops0_cnt   = r_ops0;
      ops1_cnt   = r_ops1;
      if (r_state == RESP) begin
        if (r_owner) begin
          rsp1_valid = 1'b1;
          rsp1_data  = r_res;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = r_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_f51m_sched.sv
// ---------------------------------------------------------------------------
// tb_f51m_sched
//   Drives two schedulers (FU_LAT = 1 and FU_LAT = 3) from the same request
//   and response-ready stimulus. Each has its own transaction-level reference
//   model: an operation is either absent or in flight with an age in cycles;
//   the response is due once the age reaches FU_LAT and carries op + 1.
//   The external unit returns fu_in + 1, except that on the FU_LAT = 3
//   instance it returns a corrupted value in the first two EXEC cycles.
// ---------------------------------------------------------------------------
module tb_f51m_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       rsp0_ready, rsp1_ready;

  wire  [1:0] a_rdy, a_vld, b_rdy, b_vld;
  wire  [7:0] a_d0, a_d1, a_fu_in, a_c0, a_c1;
  wire  [7:0] b_d0, b_d1, b_fu_in, b_c0, b_c1;
  wire        a_busy, b_busy;
  logic [7:0] a_fu_out, b_fu_out;

  // reference model state, index 0 = FU_LAT 1, index 1 = FU_LAT 3
  int         lat [2] = '{1, 3};
  bit         m_inflight [2];
  int         m_k [2];
  int         m_owner [2];
  logic [7:0] m_op [2];
  int         m_last [2];
  logic [7:0] m_cnt [2][2];
  bit         m_quiet [2];

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         acc_log [$];
  int         acc_cyc [$];
  int         hs_cyc [$];
  logic [7:0] rsp_log [$];
  int         n_hs1 = 0;

  f51m_sched #(.FU_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(a_rdy[0]), .req1_ready(a_rdy[1]),
    .rsp0_valid(a_vld[0]), .rsp1_valid(a_vld[1]),
    .rsp0_data(a_d0), .rsp1_data(a_d1),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .fu_in(a_fu_in), .fu_out(a_fu_out), .busy(a_busy),
    .ops0_cnt(a_c0), .ops1_cnt(a_c1)
  );

  f51m_sched #(.FU_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(b_rdy[0]), .req1_ready(b_rdy[1]),
    .rsp0_valid(b_vld[0]), .rsp1_valid(b_vld[1]),
    .rsp0_data(b_d0), .rsp1_data(b_d1),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .fu_in(b_fu_in), .fu_out(b_fu_out), .busy(b_busy),
    .ops0_cnt(b_c0), .ops1_cnt(b_c1)
  );

  // Shared unit model; x ^ 0xA5 never equals x + 1, so an early capture shows.
  always_comb begin
    a_fu_out = a_fu_in + 8'd1;
    if (m_inflight[1] && (m_k[1] < 2)) b_fu_out = b_fu_in ^ 8'hA5;
    else                               b_fu_out = b_fu_in + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_inflight[d] = 1'b0;
      m_k[d]        = 0;
      m_owner[d]    = 0;
      m_op[d]       = 8'h00;
      m_last[d]     = 1;
      m_cnt[d][0]   = 8'h00;
      m_cnt[d][1]   = 8'h00;
      m_quiet[d]    = 1'b1;
    end
  endtask

  task automatic set_in(input logic r, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1,
                        input logic r0, input logic r1);
    rst = r; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete(); hs_cyc.delete(); rsp_log.delete();
    n_hs1 = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model after
  // the rising edge.
  task automatic step();
    bit         ev_acc [2];
    int         ev_who [2];
    logic [7:0] ev_dat [2];
    bit         ev_hs  [2];
    bit         ev_rst;
    logic [1:0] g_rdy, g_vld, e_rdy, e_vld;
    logic [7:0] g_d0, g_d1, g_fu, g_c0, g_c1, e_d0, e_d1, e_fu, e_c0, e_c1;
    logic       g_busy, e_busy;
    logic [1:0] v, rr;
    int         grant;
    @(negedge clk);
    v  = {req1_valid, req0_valid};
    rr = {rsp1_ready, rsp0_ready};
    ev_rst = rst;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        g_rdy = a_rdy; g_vld = a_vld; g_d0 = a_d0; g_d1 = a_d1;
        g_fu = a_fu_in; g_c0 = a_c0; g_c1 = a_c1; g_busy = a_busy;
      end else begin
        g_rdy = b_rdy; g_vld = b_vld; g_d0 = b_d0; g_d1 = b_d1;
        g_fu = b_fu_in; g_c0 = b_c0; g_c1 = b_c1; g_busy = b_busy;
      end
      e_rdy = 2'b00; e_vld = 2'b00; e_d0 = 8'h00; e_d1 = 8'h00;
      e_fu = 8'h00; e_c0 = 8'h00; e_c1 = 8'h00; e_busy = 1'b0;
      if (!(rst || m_quiet[d])) begin
        e_fu   = m_op[d];
        e_busy = m_inflight[d];
        e_c0   = m_cnt[d][0];
        e_c1   = m_cnt[d][1];
        if (!m_inflight[d]) begin
          grant = -1;
          if (v[0] && v[1]) grant = (m_last[d] == 1) ? 0 : 1;
          else if (v[0])    grant = 0;
          else if (v[1])    grant = 1;
          if (grant >= 0) e_rdy[grant] = 1'b1;
        end else if (m_k[d] >= lat[d]) begin
          e_vld[m_owner[d]] = 1'b1;
          if (m_owner[d] == 0) e_d0 = m_op[d] + 8'd1;
          else                 e_d1 = m_op[d] + 8'd1;
        end
      end
      chk($sformatf("d%0d_req0_ready", d), 32'(g_rdy[0]), 32'(e_rdy[0]));
      chk($sformatf("d%0d_req1_ready", d), 32'(g_rdy[1]), 32'(e_rdy[1]));
      chk($sformatf("d%0d_rsp0_valid", d), 32'(g_vld[0]), 32'(e_vld[0]));
      chk($sformatf("d%0d_rsp1_valid", d), 32'(g_vld[1]), 32'(e_vld[1]));
      chk($sformatf("d%0d_rsp0_data", d), 32'(g_d0), 32'(e_d0));
      chk($sformatf("d%0d_rsp1_data", d), 32'(g_d1), 32'(e_d1));
      chk($sformatf("d%0d_fu_in", d), 32'(g_fu), 32'(e_fu));
      chk($sformatf("d%0d_busy", d), 32'(g_busy), 32'(e_busy));
      chk($sformatf("d%0d_ops0_cnt", d), 32'(g_c0), 32'(e_c0));
      chk($sformatf("d%0d_ops1_cnt", d), 32'(g_c1), 32'(e_c1));
      ev_acc[d] = (e_rdy & v) != 2'b00;
      ev_who[d] = e_rdy[1] ? 1 : 0;
      ev_dat[d] = e_rdy[1] ? req1_data : req0_data;
      ev_hs[d]  = (e_vld & rr) != 2'b00;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ev_rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_quiet[d] = 1'b0;
        if (ev_acc[d]) begin
          m_inflight[d] = 1'b1;
          m_k[d]        = 0;
          m_owner[d]    = ev_who[d];
          m_op[d]       = ev_dat[d];
          if (d == 0) begin acc_log.push_back(ev_who[d]); acc_cyc.push_back(cyc); end
        end else if (m_inflight[d]) begin
          if (ev_hs[d]) begin
            m_inflight[d] = 1'b0;
            m_last[d]     = m_owner[d];
            m_cnt[d][m_owner[d]] = m_cnt[d][m_owner[d]] + 8'd1;
            if (d == 0) begin
              rsp_log.push_back(m_op[d] + 8'd1);
              hs_cyc.push_back(cyc);
              if (m_owner[d] == 1) n_hs1++;
            end
          end else if (m_k[d] < lat[d]) begin
            m_k[d]++;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    step(); step();
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    step();
    clear_logs();
  endtask

  initial begin
    model_reset();
    do_reset();

    // single op on req0
    set_in(1'b0, 1'b1, 8'h35, 1'b0, 8'h00, 1'b1, 1'b1);
    step();
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("single_rsp_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() > 0) begin
      chk("single_rsp_data", 32'(rsp_log[0]), 32'h36);
      chk("single_latency", 32'(hs_cyc[0] - acc_cyc[0]), 32'd2);
    end
    chk("single_ops0", 32'(a_c0), 32'd1);

    // tie arbitration
    do_reset();
    set_in(1'b0, 1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step();
    chk("tie_accepts", 32'(acc_log.size() >= 4), 32'd1);
    if (acc_log.size() >= 4 && rsp_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tie_order%0d", i), 32'(acc_log[i]), 32'(i % 2));
        chk($sformatf("tie_rsp%0d", i), 32'(rsp_log[i]), (i % 2 == 0) ? 32'h11 : 32'h21);
      end
    end

    // backpressure on rsp0 with req1 waiting
    do_reset();
    set_in(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step();
    rsp0_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("bp_accepts", 32'(acc_log.size() >= 2 && hs_cyc.size() >= 1), 32'd1);
    if (acc_log.size() >= 2 && hs_cyc.size() >= 1) begin
      chk("bp_second_owner", 32'(acc_log[1]), 32'd1);
      chk("bp_gap", 32'(acc_cyc[1] - hs_cyc[0]), 32'd1);
    end

    // reset in the middle of EXEC
    do_reset();
    set_in(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1);
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rstmid_no_rsp", 32'(rsp_log.size()), 32'd0);
    chk("rstmid_ops0", 32'(a_c0), 32'd0);
    set_in(1'b0, 1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b1);
    step();
    chk("rstmid_accepts", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) chk("rstmid_tie_grant", 32'(acc_log[1]), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      set_in(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 2) != 0), 8'($urandom),
             ($urandom_range(0, 2) != 0), 8'($urandom),
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
      step();
    end

    // 256 operations on req1 wrap its counter
    do_reset();
    for (int i = 0; i < 1500 && n_hs1 < 256; i++) begin
      set_in(1'b0, 1'b0, 8'h00, 1'b1, 8'($urandom), 1'b1, 1'b1);
      step();
    end
    chk("wrap_ops_done", 32'(n_hs1), 32'd256);
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    step();
    chk("wrap_ops1", 32'(a_c1), 32'd0);
    chk("wrap_ops0", 32'(a_c0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/f51m_sched.md
F51M_SCHED -- requirements
Module: f51m_sched

Interface
REQ-001 SHALL have parameter FU_LAT, default 1, legal range 1..7: cycles the shared function unit needs to settle; fu_out is sampled in the last of those cycles.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports req0_valid, req1_valid, input, 1: request valid per requester.
REQ-005 SHALL have ports req0_data, req1_data, input, 8: operand per requester.
REQ-006 SHALL have ports req0_ready, req1_ready, output, 1: request accepted this cycle when valid&ready.
REQ-007 SHALL have ports rsp0_valid, rsp1_valid, output, 1: response valid per requester.
REQ-008 SHALL have ports rsp0_data, rsp1_data, output, 8: result per requester.
REQ-009 SHALL have ports rsp0_ready, rsp1_ready, input, 1: response consumed when valid&ready.
REQ-010 SHALL have port fu_in, output, 8: operand driven to the shared external 8-in/8-out combinational unit.
REQ-011 SHALL have port fu_out, input, 8: result from the shared unit.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have ports ops0_cnt, ops1_cnt, output, 8: completed-response count per requester.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-015 SHALL, in IDLE, assert exactly one reqN_ready, combinationally, for the granted requester; in EXEC/RESP both req_ready SHALL be 0.
REQ-016 SHALL grant round-robin: one requester valid -> that one; both valid -> the one not equal to last_grant; none valid -> no ready.
REQ-017 SHALL, on request handshake, latch the operand into op_reg, record the owner, load the cycle counter with FU_LAT, and move IDLE->EXEC.
REQ-018 SHALL drive fu_in = op_reg at all times; op_reg holds its value until the next accept.
REQ-019 SHALL stay in EXEC exactly FU_LAT cycles, capture fu_out into res_reg on the last EXEC cycle, and move EXEC->RESP.
REQ-020 SHALL, in RESP, assert rspK_valid for the owner only, with rspK_data = res_reg; the non-owner's rsp_valid = 0 and rsp_data = 0.
REQ-021 SHALL hold rsp_valid and rsp_data stable while the owner's rsp_ready = 0, for any number of cycles.
REQ-022 SHALL, on response handshake: move RESP->IDLE; set last_grant = owner; increment the owner's opsN_cnt mod 256 (255->0).
REQ-023 SHALL ignore rsp_ready outside RESP, and ignore the non-owner's rsp_ready.
REQ-024 SHALL give latency: accept at edge T -> rsp_valid high from the cycle after edge T+FU_LAT; minimum issue interval FU_LAT+2 cycles.
REQ-025 SHALL tolerate req_valid dropping before acceptance; no request is latched without a handshake.

Reset
REQ-026 SHALL, when rst=1 at an edge, set state=IDLE, op_reg=0, res_reg=0, last_grant=1 (req0 wins the first tie), opsN_cnt=0, counter=0.
REQ-027 SHALL, while rst=1 and in the cycle after, drive all outputs to 0 (fu_in=0, busy=0, all ready/valid/data=0).
REQ-028 SHALL, on reset mid-EXEC or mid-RESP, discard the operation: no response issued, no counter increment.

Verification (bench model: fu_out = fu_in + 1 mod 256)
REQ-029 SHALL cover single op: FU_LAT=1, req0_valid with 0x35 after reset -> req0_ready=1 same cycle; rsp0_valid 2 cycles after accept; rsp0_data=0x36; ops0_cnt=1.
REQ-030 SHALL cover tie arbitration: both valid continuously, data 0x10/0x20 -> accepts ordered req0, req1, req0, req1; responses 0x11, 0x21, 0x11, 0x21.
REQ-031 SHALL cover backpressure: rsp0_ready=0 for 5 cycles with req1 valid -> rsp0_valid and rsp0_data held, busy=1, req1_ready=0 throughout; req1 accepted in the first IDLE cycle after the rsp0 handshake.
REQ-032 SHALL cover FU_LAT=3: bench model changes fu_out mid-EXEC (value in EXEC cycles 1-2 != value in cycle 3) -> res_reg equals the EXEC-cycle-3 value; rsp_valid 4 cycles after accept.
REQ-033 SHALL cover reset mid-EXEC: rst pulsed during EXEC -> next cycle all outputs 0, no rsp, opsN_cnt=0; next tie grant goes to req0.
REQ-034 SHALL cover counter wrap: 256 completed ops on req1 -> ops1_cnt returns to 0x00, ops0_cnt unchanged.
